// File: rtl/core_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : core_block_ctrl
// Brief   : Per-core thread-block launcher: splits a block into warps, issues
//           them, tracks outstanding warps and signals block completion.
// Rev     : 1.0
// ============================================================================
module core_block_ctrl #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   block_id,
    input  logic [7:0]                   threads_per_block,
    output logic                         warp_valid,
    input  logic                         warp_ready,
    output logic [$clog2(NUM_WARPS)-1:0] warp_id,
    output logic [15:0]                  warp_thread_base,
    output logic [THREADS_PER_WARP-1:0]  warp_mask,
    input  logic                         retire_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] retire_warp,
    output logic                         done,
    output logic                         cfg_error
);

    localparam int WID_W       = $clog2(NUM_WARPS);
    localparam int NW_W        = $clog2(NUM_WARPS + 1);
    localparam int MAX_THREADS = NUM_WARPS * THREADS_PER_WARP;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [WID_W-1:0]     w_q, w_d;
    logic [NW_W-1:0]      nwarps_q, nwarps_d;
    logic [7:0]           rem_q, rem_d;
    logic [15:0]          base_q, base_d;
    logic [NUM_WARPS-1:0] outstanding_q, outstanding_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 done_q, done_d;

    logic                 tpb_over;
    logic [7:0]           tpb_clamped;
    logic                 last_warp;

    // Launch-time block geometry, derived from the live inputs
    always_comb begin
        tpb_over    = (32'(threads_per_block) > MAX_THREADS);
        tpb_clamped = tpb_over ? 8'(MAX_THREADS) : threads_per_block;
    end

    assign last_warp = (32'(w_q) == (32'(nwarps_q) - 32'd1));

    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        nwarps_d      = nwarps_q;
        rem_d         = rem_q;
        base_d        = base_q;
        outstanding_d = outstanding_q;
        cfg_error_d   = cfg_error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                nwarps_d = NW_W'((32'(tpb_clamped) + THREADS_PER_WARP - 1) / THREADS_PER_WARP);
                rem_d    = tpb_clamped;
                base_d   = 16'(block_id) * 16'(tpb_clamped);
                w_d      = '0;
                if (tpb_over) begin
                    cfg_error_d = 1'b1;
                end
                state_d  = (tpb_clamped == 8'd0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (warp_ready) begin
                    w_d    = w_q + WID_W'(1);
                    base_d = base_q + 16'(THREADS_PER_WARP);
                    rem_d  = (rem_q > 8'(THREADS_PER_WARP)) ? rem_q - 8'(THREADS_PER_WARP) : 8'd0;
                    if (last_warp) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Retire clears first so a same-cycle issue of another warp still lands
        if ((state_q == ISSUE || state_q == DRAIN) && retire_valid) begin
            outstanding_d[retire_warp] = 1'b0;
        end
        if (state_q == ISSUE && warp_ready) begin
            outstanding_d[w_q] = 1'b1;
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            w_q           <= '0;
            nwarps_q      <= '0;
            rem_q         <= '0;
            base_q        <= '0;
            outstanding_q <= '0;
            cfg_error_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            nwarps_q      <= nwarps_d;
            rem_q         <= rem_d;
            base_q        <= base_d;
            outstanding_q <= outstanding_d;
            cfg_error_q   <= cfg_error_d;
            done_q        <= done_d;
        end
    end

    // Lanes below the remaining thread count are active
    always_comb begin
        warp_mask = '0;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            warp_mask[i] = (int'(rem_q) > i);
        end
    end

    assign warp_valid       = (state_q == ISSUE);
    assign warp_id          = w_q;
    assign warp_thread_base = base_q;
    assign done             = done_q;
    assign cfg_error        = cfg_error_q;

endmodule
`default_nettype wire

// File: tb/tb_core_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_block_ctrl
// Brief   : Self-checking bench: directed scenarios plus randomized blocks
//           compared against a cycle-level behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_core_block_ctrl;

    localparam int NW   = 4;
    localparam int TPW  = 8;
    localparam int MAXT = NW * TPW;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  block_id;
    logic [7:0]  threads_per_block;
    logic        warp_valid;
    logic        warp_ready;
    logic [1:0]  warp_id;
    logic [15:0] warp_thread_base;
    logic [7:0]  warp_mask;
    logic        retire_valid;
    logic [1:0]  retire_warp;
    logic        done;
    logic        cfg_error;

    int checks   = 0;
    int failures = 0;
    bit exp_cfg  = 1'b0;
    int stall_warp_g = -1;
    int stall_len_g  = 0;
    int order_q[$];

    always #5 clk = ~clk;

    core_block_ctrl #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .block_id          (block_id),
        .threads_per_block (threads_per_block),
        .warp_valid        (warp_valid),
        .warp_ready        (warp_ready),
        .warp_id           (warp_id),
        .warp_thread_base  (warp_thread_base),
        .warp_mask         (warp_mask),
        .retire_valid      (retire_valid),
        .retire_warp       (retire_warp),
        .done              (done),
        .cfg_error         (cfg_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit with_start);
        reset        = 1'b1;
        start        = with_start;
        block_id     = 8'd0;
        threads_per_block = 8'd0;
        warp_ready   = 1'b0;
        retire_valid = 1'b0;
        retire_warp  = 2'd0;
        @(posedge clk); #1;
        exp_cfg = 1'b0;
        check("rst_valid", 32'(warp_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cfg", 32'(cfg_error), 32'd0);
        check("rst_id", 32'(warp_id), 32'd0);
        check("rst_base", 32'(warp_thread_base), 32'd0);
        check("rst_mask", 32'(warp_mask), 32'd0);
        reset = 1'b0;
    endtask

    // Drives one block launch. Edge k=0 is the edge that samples start in IDLE.
    task automatic run_block(input int bid, input int tpb, input int ready_pct,
                             input int retire_pct, input int abort_after, input bit drop_start);
        int tpbc;
        int nw;
        bit outs[NW];
        int n_iss;
        bit exp_done;
        bit empty_seen;
        bit exp_valid;
        bit ready_a;
        bit rv_a;
        int rw_a;
        int stall_left;
        bit dut_valid_prev;
        int fires_obs;
        int done_hold;
        bit finished;
        tpbc = (tpb > MAXT) ? MAXT : tpb;
        nw   = (tpbc + TPW - 1) / TPW;
        foreach (outs[i]) outs[i] = 1'b0;
        n_iss = 0; exp_done = 0; empty_seen = 0; exp_valid = 0;
        ready_a = 0; rv_a = 0; rw_a = 0; stall_left = stall_len_g;
        dut_valid_prev = 0; fires_obs = 0; done_hold = 0; finished = 0;

        block_id          = 8'(bid);
        threads_per_block = 8'(tpb);
        start             = 1'b1;
        warp_ready        = 1'b0;
        retire_valid      = 1'b0;

        for (int k = 0; k < 300; k++) begin
            bit fire;
            bit empty;
            int rem;
            logic [7:0] exp_mask;
            int cand[$];
            @(posedge clk); #1;
            if (dut_valid_prev && ready_a) fires_obs++;

            fire = exp_valid && ready_a;
            if (k >= 2 && !exp_done && rv_a) outs[rw_a] = 1'b0;
            if (fire) begin
                outs[n_iss] = 1'b1;
                n_iss++;
            end
            empty = 1'b1;
            foreach (outs[i]) if (outs[i]) empty = 1'b0;
            if (k == 1 && nw == 0) begin
                exp_done = 1'b1;
            end else if (k >= 2 && n_iss == nw && empty) begin
                if (empty_seen) exp_done = 1'b1;
                empty_seen = 1'b1;
            end
            if (k == 1 && tpb > MAXT) exp_cfg = 1'b1;
            exp_valid = (k >= 1) && (n_iss < nw) && !exp_done;

            check("warp_valid", 32'(warp_valid), 32'(exp_valid));
            check("done", 32'(done), 32'(exp_done));
            check("cfg_error", 32'(cfg_error), 32'(exp_cfg));
            if (exp_valid) begin
                rem = tpbc - TPW * n_iss;
                exp_mask = (rem >= TPW) ? 8'hFF : 8'((1 << rem) - 1);
                check("warp_id", 32'(warp_id), 32'(n_iss));
                check("warp_base", 32'(warp_thread_base), 32'(bid * tpbc + TPW * n_iss));
                check("warp_mask", 32'(warp_mask), 32'(exp_mask));
            end
            dut_valid_prev = warp_valid;

            if (abort_after > 0 && k + 1 >= abort_after) break;
            if (exp_done) begin
                done_hold++;
                if (done_hold >= 3) begin
                    finished = 1'b1;
                    break;
                end
            end

            if (drop_start && k >= 1) start = 1'b0;
            if (stall_warp_g >= 0 && exp_valid && n_iss == stall_warp_g && stall_left > 0) begin
                ready_a = 1'b0;
                stall_left--;
            end else begin
                ready_a = ($urandom_range(99, 0) < ready_pct);
            end

            rv_a = 1'b0;
            if (order_q.size() > 0) begin
                if (n_iss == nw && k >= 2) begin
                    rv_a = 1'b1;
                    rw_a = order_q.pop_front();
                end
            end else if ($urandom_range(99, 0) < retire_pct) begin
                foreach (outs[i]) if (outs[i]) cand.push_back(i);
                rv_a = 1'b1;
                if (cand.size() > 0 && $urandom_range(3, 0) != 0)
                    rw_a = cand[$urandom_range(cand.size() - 1, 0)];
                else
                    rw_a = int'($urandom_range(NW - 1, 0));
            end
            warp_ready   = ready_a;
            retire_valid = rv_a;
            retire_warp  = 2'(rw_a);
        end

        if (abort_after == 0) begin
            check("completed", 32'(finished), 32'd1);
            check("issue_count", 32'(fires_obs), 32'(nw));
        end
        warp_ready   = 1'b0;
        retire_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; block_id = 8'd0; threads_per_block = 8'd0;
        warp_ready = 1'b0; retire_valid = 1'b0; retire_warp = 2'd0;

        do_reset(1'b0);
        run_block(3, 32, 100, 100, 0, 1'b0);        // four full warps, bases 96..120

        do_reset(1'b0);
        run_block(7, 13, 100, 100, 0, 1'b0);        // partial last warp, mask 0x1F
        do_reset(1'b0);
        run_block(9, 0, 100, 100, 0, 1'b0);         // empty block

        do_reset(1'b0);
        stall_warp_g = 1; stall_len_g = 5;
        run_block(1, 32, 100, 60, 0, 1'b0);         // back-pressure on warp 1
        stall_warp_g = -1; stall_len_g = 0;

        do_reset(1'b0);
        run_block(2, 40, 100, 100, 0, 1'b1);        // overflow clamps to 32 threads
        do_reset(1'b0);

        order_q = '{2, 0, 0, 3, 1};
        run_block(4, 32, 100, 0, 0, 1'b0);          // out-of-order and duplicate retires
        order_q.delete();

        do_reset(1'b0);
        run_block(3, 32, 100, 0, 8, 1'b0);          // leave the block parked in DRAIN
        do_reset(1'b0);
        run_block(5, 8, 100, 100, 0, 1'b0);         // clean restart, base 40

        do_reset(1'b1);                              // reset and start together
        run_block(11, 17, 100, 100, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int tpb;
            int sel;
            sel = int'($urandom_range(9, 0));
            if (sel == 0)      tpb = 0;
            else if (sel == 1) tpb = int'($urandom_range(255, MAXT + 1));
            else               tpb = int'($urandom_range(MAXT, 1));
            do_reset($urandom_range(3, 0) == 0);
            run_block(int'($urandom_range(255, 0)), tpb, int'($urandom_range(100, 30)),
                      int'($urandom_range(90, 20)), 0, $urandom_range(1, 0) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_block_ctrl.md
CORE_BLOCK_CTRL -- requirements
Module: core_block_ctrl

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, maximum warps per block.
REQ-002 SHALL have parameter THREADS_PER_WARP, default 8, lanes per warp.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset, driven by the dispatcher's per-core reset.
REQ-005 SHALL have port start, input, 1 bit, block launch request, held high by the dispatcher until done is seen.
REQ-006 SHALL have port block_id, input, 8 bits, block index, valid while start is high.
REQ-007 SHALL have port threads_per_block, input, 8 bits, thread count of the kernel.
REQ-008 SHALL have port warp_valid, output, 1 bit, warp issue request.
REQ-009 SHALL have port warp_ready, input, 1 bit, issue accepted when high with warp_valid.
REQ-010 SHALL have port warp_id, output, $clog2(NUM_WARPS) bits, index of the warp being issued.
REQ-011 SHALL have port warp_thread_base, output, 16 bits, global thread id of lane 0.
REQ-012 SHALL have port warp_mask, output, THREADS_PER_WARP bits, active lanes.
REQ-013 SHALL have port retire_valid, input, 1 bit, warp completion strobe.
REQ-014 SHALL have port retire_warp, input, $clog2(NUM_WARPS) bits, completing warp index.
REQ-015 SHALL have port done, output, 1 bit, block complete, held until reset.
REQ-016 SHALL have port cfg_error, output, 1 bit, sticky threads_per_block overflow flag.

Function
REQ-017 SHALL implement states IDLE, LAUNCH, ISSUE, DRAIN, DONE.
REQ-018 IDLE: start=1 -> LAUNCH next cycle; start is ignored in every other state.
REQ-019 LAUNCH (1 cycle): latch block_id; compute tpb = min(threads_per_block, NUM_WARPS*THREADS_PER_WARP); compute nwarps = ceil(tpb/THREADS_PER_WARP); compute block_base = block_id*tpb as 16-bit unsigned with no truncation (max 255*255 fits); tpb=0 -> DONE, else -> ISSUE.
REQ-020 cfg_error SHALL be set in LAUNCH when threads_per_block > NUM_WARPS*THREADS_PER_WARP and cleared only by reset.
REQ-021 ISSUE: warp_valid=1 with warp_id=w, starting at w=0; warp_thread_base=block_base+w*THREADS_PER_WARP.
REQ-022 warp_mask SHALL be all ones, except for the last warp, which has its low (tpb - w*THREADS_PER_WARP) bits set.
REQ-023 Issue outputs SHALL stay stable while warp_valid=1 and warp_ready=0.
REQ-024 On warp_valid&warp_ready: set outstanding[w]; increment w; if w was nwarps-1 -> DRAIN.
REQ-025 First warp_valid SHALL assert 2 cycles after the cycle where start is sampled high in IDLE.
REQ-026 retire_valid SHALL clear outstanding[retire_warp] in ISSUE or DRAIN.
REQ-027 A retire for a warp not outstanding SHALL be ignored.
REQ-028 A retire in the same cycle as an issue of a different warp SHALL apply both.
REQ-029 DRAIN: when outstanding is zero (including a retire that clears the last bit this cycle, evaluated next cycle) -> DONE.
REQ-030 DONE: done=1 (registered, state==DONE); warp_valid=0; remain until reset.
REQ-031 warp_valid SHALL be 0 in all states except ISSUE.
REQ-032 Deassertion of start after LAUNCH SHALL NOT affect operation.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL enter IDLE and clear done, cfg_error, warp_valid, outstanding, w, warp_id, warp_thread_base and warp_mask to 0.
REQ-034 Reset SHALL override every state, including mid-ISSUE and mid-DRAIN, and SHALL discard pending retires.
REQ-035 With reset and start both high in the same cycle, reset SHALL win and start SHALL be sampled no earlier than the next cycle.

Verification
REQ-036 Directed test: block_id=3, tpb=32, warp_ready=1, immediate retires -> warps 0..3 with bases 96,104,112,120, masks 0xFF; done high after last retire+1 cycle.
REQ-037 Directed test: tpb=13 -> 2 warps, masks 0xFF and 0x1F; tpb=0 -> no warp_valid; done 2 cycles after start.
REQ-038 Directed test: warp_ready low for 5 cycles on warp 1 -> warp_id, base and mask stable throughout; exactly 4 issues in total.
REQ-039 Directed test: tpb=40 -> cfg_error=1, 4 full warps issued; cfg_error stays high after done until reset.
REQ-040 Directed test: out-of-order retires 2,0,3,1 plus a duplicate retire of 0 -> done only after warp 1 retires.
REQ-041 Directed test: reset asserted mid-DRAIN, then start with block_id=5, tpb=8 -> clean restart with one warp, base 40, mask 0xFF.
